// File: rtl/w5300_lut_sequencer.sv
// ---------------------------------------------------------------------------
// w5300_lut_sequencer
// Walks a LUT from FIRST_INDEX to LAST_INDEX and turns each entry into one
// W5300 host-bus read or write cycle (SETUP / STROBE / HOLD phases). Entries
// whose address is 10'h3ff are skipped without touching the bus.
//
// Ports
//   clk_i        rising-edge clock
//   rst_n_i      asynchronous active-low reset
//   start_i      start one run (only looked at in IDLE)
//   busy_o       high whenever not IDLE
//   done_o       one-cycle pulse at end of run
//   index_o      LUT address
//   lut_data_i   {op(1=read), addr[9:0], wdata[15:0]} for index_o
//   bus_*_o      W5300 bus: addr, wdata, data output enable, cs_n/wr_n/rd_n
//   bus_rdata_i  data pins from the W5300
//   rd_valid_o   one-cycle pulse with rd_data_o holding the read value
// ---------------------------------------------------------------------------
module w5300_lut_sequencer #(
   parameter logic [5:0] FIRST_INDEX = 6'h01,
   parameter logic [5:0] LAST_INDEX  = 6'h10,
   parameter logic [3:0] SETUP_CYC   = 4'd1,
   parameter logic [3:0] STROBE_CYC  = 4'd4,
   parameter logic [3:0] HOLD_CYC    = 4'd1
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [5:0]  index_o,
   input  logic [26:0] lut_data_i,
   output logic [9:0]  bus_addr_o,
   output logic [15:0] bus_wdata_o,
   output logic        bus_data_oe_o,
   output logic        bus_cs_n_o,
   output logic        bus_wr_n_o,
   output logic        bus_rd_n_o,
   input  logic [15:0] bus_rdata_i,
   output logic        rd_valid_o,
   output logic [15:0] rd_data_o
);

   typedef enum logic [2:0] {
      IDLE, FETCH, SETUP, STROBE, HOLD, NEXT, DONE
   } state_t;

   state_t      state_q;
   logic [3:0]  cnt_q, cnt_d;
   logic        op_q;
   logic        busy_q, done_q, rd_valid_q;
   logic [5:0]  index_q;
   logic [9:0]  addr_q;
   logic [15:0] wdata_q, rd_data_q;
   logic        oe_q, cs_n_q, wr_n_q, rd_n_q;

   // Phase counter decrement; the phase ends on the cycle it reads zero.
   always_comb begin
      cnt_d = cnt_q - 4'd1;
   end

   // All outputs are set on the transition into the state that shows them,
   // so every output is a flop and lut_data/bus_rdata never reach a pin
   // combinationally.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         op_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         index_q    <= 6'h00;
         addr_q     <= 10'h000;
         wdata_q    <= 16'h0000;
         rd_data_q  <= 16'h0000;
         oe_q       <= 1'b0;
         cs_n_q     <= 1'b1;
         wr_n_q     <= 1'b1;
         rd_n_q     <= 1'b1;
      end else begin
         done_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  index_q <= FIRST_INDEX;
                  busy_q  <= 1'b1;
                  state_q <= FETCH;
               end
            end
            FETCH: begin
               // lut_data is valid for the whole FETCH cycle, so the entry
               // is latched and decoded at the same edge.
               op_q <= lut_data_i[26];
               if (lut_data_i[25:16] == 10'h3ff) begin
                  state_q <= NEXT;
               end else begin
                  addr_q  <= lut_data_i[25:16];
                  wdata_q <= lut_data_i[15:0];
                  oe_q    <= ~lut_data_i[26];
                  cs_n_q  <= 1'b0;
                  cnt_q   <= SETUP_CYC - 4'd1;
                  state_q <= SETUP;
               end
            end
            SETUP: begin
               if (cnt_q == 4'd0) begin
                  wr_n_q  <= op_q;
                  rd_n_q  <= ~op_q;
                  cnt_q   <= STROBE_CYC - 4'd1;
                  state_q <= STROBE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            STROBE: begin
               if (cnt_q == 4'd0) begin
                  wr_n_q  <= 1'b1;
                  rd_n_q  <= 1'b1;
                  if (op_q) begin
                     rd_data_q  <= bus_rdata_i;
                     rd_valid_q <= 1'b1;
                  end
                  cnt_q   <= HOLD_CYC - 4'd1;
                  state_q <= HOLD;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            HOLD: begin
               if (cnt_q == 4'd0) begin
                  cs_n_q  <= 1'b1;
                  oe_q    <= 1'b0;
                  state_q <= NEXT;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            NEXT: begin
               if (index_q == LAST_INDEX) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  index_q <= index_q + 6'd1;
                  state_q <= FETCH;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign index_o       = index_q;
   assign bus_addr_o    = addr_q;
   assign bus_wdata_o   = wdata_q;
   assign bus_data_oe_o = oe_q;
   assign bus_cs_n_o    = cs_n_q;
   assign bus_wr_n_o    = wr_n_q;
   assign bus_rd_n_o    = rd_n_q;
   assign rd_valid_o    = rd_valid_q;
   assign rd_data_o     = rd_data_q;

endmodule
